// File: rtl/regfile_seq_ctrl.sv
// regfile_seq_ctrl
// Multi-cycle sequencer driving a 4x4 two-read/one-write register file.
// One 9-bit instruction is accepted per valid/ready handshake and walks
// IDLE -> READ -> EXEC -> WB, so throughput is one instruction per 4 cycles.
//
// Ports:
//   clk, nRST            clock (rising edge), asynchronous active-low reset
//   instr, instr_valid   instruction [8:6] op, [5:4] rd, [3:2] ra, [1:0] rb
//   instr_ready          high only in IDLE
//   A_addr, B_addr       register file read addresses (registered at accept)
//   A_data, B_data       register file read data (combinational from addresses)
//   nWE, D_addr, D_data  register file write port, nWE active low in WB
//   done                 one-cycle pulse in the write-back cycle
//   busy                 high whenever the state is not IDLE
//   flag_z, flag_c       zero / carry(borrow) flags of the last ALU operation
module regfile_seq_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic [8:0]        instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] A_addr,
    output logic [ADDR_W-1:0] B_addr,
    input  logic [DATA_W-1:0] A_data,
    input  logic [DATA_W-1:0] B_data,
    output logic              nWE,
    output logic [ADDR_W-1:0] D_addr,
    output logic [DATA_W-1:0] D_data,
    output logic              done,
    output logic              busy,
    output logic              flag_z,
    output logic              flag_c
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    typedef enum logic [2:0] {
        OP_NOP, OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              carry_q;

    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic [DATA_W:0]   sum;
    logic              accept;
    logic              alu_op;

    assign accept = instr_valid && (state_q == IDLE);
    // Only ADD..XOR touch the flags; NOP, LDI and MOV leave them alone.
    assign alu_op = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND) ||
                    (op_q == OP_OR)  || (op_q == OP_XOR);

    // State register
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = READ;
            READ: state_d = EXEC;
            EXEC: state_d = WB;
            WB:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; reset forces IDLE asynchronously, which
    // releases nWE in the same instant a reset hits during WB.
    always_comb begin
        instr_ready = (state_q == IDLE);
        busy        = (state_q != IDLE);
        done        = (state_q == WB);
        nWE         = !((state_q == WB) && (op_q != OP_NOP));
    end

    // Built-in ALU working on the captured operands
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        alu_res = '0;
        alu_c   = 1'b0;
        unique case (op_q)
            OP_NOP: alu_res = '0;
            OP_LDI: alu_res = imm_q;
            OP_MOV: alu_res = a_q;
            OP_ADD: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            OP_SUB: begin
                alu_res = a_q - b_q;
                alu_c   = (a_q < b_q);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            default: alu_res = '0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            op_q    <= OP_NOP;
            rd_q    <= '0;
            imm_q   <= '0;
            A_addr  <= '0;
            B_addr  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            D_addr  <= '0;
            D_data  <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    op_q   <= op_t'(instr[8:6]);
                    rd_q   <= instr[5:4];
                    imm_q  <= instr[DATA_W-1:0];
                    A_addr <= instr[3:2];
                    B_addr <= instr[1:0];
                end
                READ: begin
                    a_q <= A_data;
                    b_q <= B_data;
                end
                EXEC: begin
                    // D_data doubles as the result register
                    D_data  <= alu_res;
                    carry_q <= alu_c;
                    D_addr  <= rd_q;
                end
                WB: if (alu_op) begin
                    flag_c <= carry_q;
                    flag_z <= (D_data == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Testbench for regfile_seq_ctrl: models the register file around the DUT
// and compares write-back, register contents, flags and timing against an
// instruction-level reference model, with directed and random programs.
module tb_regfile_seq_ctrl;

    logic       clk = 1'b0;
    logic       nRST;
    logic [8:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] A_addr, B_addr, D_addr;
    logic [3:0] A_data, B_data, D_data;
    logic       nWE, done, busy, flag_z, flag_c;

    regfile_seq_ctrl #(.DATA_W(4), .ADDR_W(2)) dut (
        .clk         (clk),
        .nRST        (nRST),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .A_addr      (A_addr),
        .B_addr      (B_addr),
        .A_data      (A_data),
        .B_data      (B_data),
        .nWE         (nWE),
        .D_addr      (D_addr),
        .D_data      (D_data),
        .done        (done),
        .busy        (busy),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    always #5 clk = ~clk;

    // Register file surrounding the DUT
    logic [3:0] rf [4];
    assign A_data = rf[A_addr];
    assign B_data = rf[B_addr];
    always @(posedge clk) if (!nWE) rf[D_addr] <= D_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // nWE watcher: low only with done, never two cycles in a row
    int nwe_low_cnt = 0;
    int nwe_bad     = 0;
    bit prev_low    = 0;
    always @(negedge clk) begin
        if (!nWE) begin
            nwe_low_cnt++;
            if (!done) nwe_bad++;
            if (prev_low) nwe_bad++;
        end
        prev_low = !nWE;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction-level reference model
    int ref_rf [4];
    int ref_z = 0;
    int ref_c = 0;
    int last_acc = -100;

    task automatic ref_eval(input logic [8:0] ins, output int res, output bit we,
                            output int nz, output int nc);
        int op, a, b;
        op  = int'(ins[8:6]);
        a   = ref_rf[int'(ins[3:2])];
        b   = ref_rf[int'(ins[1:0])];
        we  = (op != 0);
        res = 0;
        nz  = ref_z;
        nc  = ref_c;
        case (op)
            1: res = int'(ins[3:0]);
            2: res = a;
            3: begin res = (a + b) % 16; nc = (a + b > 15) ? 1 : 0; end
            4: begin res = (a - b + 16) % 16; nc = (a < b) ? 1 : 0; end
            5: begin res = a & b; nc = 0; end
            6: begin res = a | b; nc = 0; end
            7: begin res = a ^ b; nc = 0; end
            default: res = 0;
        endcase
        if (op >= 3) nz = (res == 0) ? 1 : 0;
    endtask

    // Issue one instruction; called and returning at a falling edge in IDLE.
    task automatic issue(input logic [8:0] ins, input bit hold, input bit chk_space);
        int t, lat, low0, res, nz, nc, rd;
        bit we;
        rd = int'(ins[5:4]);
        instr = ins;
        instr_valid = 1'b1;
        t = 0;
        while (!instr_ready && t < 20) begin @(negedge clk); t++; end
        check("ready_wait", t < 20, 1);
        if (chk_space) check("accept_spacing", cyc - last_acc, 4);
        last_acc = cyc;
        low0 = nwe_low_cnt;
        ref_eval(ins, res, we, nz, nc);
        @(negedge clk);
        if (!hold) instr_valid = $urandom_range(0, 1);
        check("ready_busy", {instr_ready, busy}, 2'b01);
        lat = 1;
        while (!done && lat < 10) begin @(negedge clk); lat++; end
        check("done_latency", lat, 3);
        check("nwe_wb", nWE, !we);
        if (we) begin
            check("wb_addr", D_addr, rd);
            check("wb_data", D_data, res);
        end
        @(negedge clk);
        if (!hold) instr_valid = 1'b0;
        if (we) ref_rf[rd] = res;
        ref_z = nz;
        ref_c = nc;
        check("nwe_count", nwe_low_cnt - low0, we);
        check("rf_rd", rf[rd], ref_rf[rd]);
        check("flag_z", flag_z, ref_z);
        check("flag_c", flag_c, ref_c);
        check("done_end", done, 0);
    endtask

    function automatic logic [8:0] enc(input int op, input int rd, input int ra, input int rb);
        enc = {op[2:0], rd[1:0], ra[1:0], rb[1:0]};
    endfunction

    initial begin
        logic [3:0] r3_old;
        int t;
        for (int i = 0; i < 4; i++) begin rf[i] = '0; ref_rf[i] = 0; end
        nRST = 1'b0;
        instr = '0;
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_nwe", nWE, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", {A_addr, B_addr, D_addr}, 0);
        check("rst_ddata", D_data, 0);
        check("rst_flags", {flag_z, flag_c}, 0);
        nRST = 1'b1;
        @(negedge clk);
        check("rst_ready", instr_ready, 1);

        // Directed program
        issue(enc(1, 1, 1, 1), 0, 0);      // LDI R1,5
        issue(enc(1, 2, 0, 3), 0, 0);      // LDI R2,3
        issue(enc(3, 3, 1, 2), 0, 0);      // ADD R3,R1,R2
        issue(enc(1, 0, 3, 3), 0, 0);      // LDI R0,F
        issue(enc(3, 3, 0, 0), 0, 0);      // ADD R3,R0,R0
        issue(enc(4, 0, 2, 1), 0, 0);      // SUB R0,R2,R1
        issue(enc(7, 1, 1, 1), 0, 0);      // XOR R1,R1,R1
        issue(enc(0, 2, 1, 0), 0, 0);      // NOP
        issue(enc(2, 2, 3, 0), 0, 0);      // MOV R2,R3

        // Dependency chain with instr_valid held high
        issue(enc(1, 0, 0, 1), 1, 0);      // LDI R0,1
        issue(enc(3, 0, 0, 0), 1, 1);
        issue(enc(3, 0, 0, 0), 1, 1);
        issue(enc(3, 0, 0, 0), 1, 1);
        check("chain_r0", rf[0], 8);
        instr_valid = 1'b0;
        @(negedge clk);

        // Reset during the write-back of LDI R3,9
        r3_old = rf[3];
        instr = enc(1, 3, 2, 1);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        t = 0;
        while (!done && t < 10) begin @(negedge clk); t++; end
        check("rwb_reach_wb", {done, nWE}, 2'b10);
        nRST = 1'b0;
        #1;
        check("rwb_nwe", nWE, 1);
        check("rwb_busy", busy, 0);
        check("rwb_done", done, 0);
        check("rwb_flags", {flag_z, flag_c}, 0);
        check("rwb_ddata", D_data, 0);
        @(negedge clk);
        check("rwb_r3", rf[3], r3_old);
        nRST = 1'b1;
        ref_z = 0;
        ref_c = 0;
        @(negedge clk);
        check("rwb_ready", instr_ready, 1);

        // Random program
        for (int i = 0; i < 60; i++)
            issue(9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), 0);

        for (int i = 0; i < 4; i++) check("final_rf", rf[i], ref_rf[i]);
        check("nwe_protocol", nwe_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/regfile_seq_ctrl.md
Name: regfile_seq_ctrl

Overview:
Multi-cycle sequencer that executes a small 4-bit instruction set against the 4x4 two-read/one-write register file. It accepts one 9-bit instruction per valid/ready handshake, drives register file read addresses, captures operands, computes the result in a built-in 4-bit ALU, and performs write-back through the file's active-low write enable. It sits between an instruction source (testbench, ROM walker or host) and the register file, and is the only writer of that file.

Parameters:
DATA_W, 4, data width; must match the register file (fixed 4).
ADDR_W, 2, register address width; must match the register file (fixed 2).

Ports:
clk  input  1  system clock, rising-edge active
nRST  input  1  asynchronous active-low reset
instr  input  9  instruction: [8:6] opcode, [5:4] rd, [3:2] ra, [1:0] rb; LDI immediate = instr[3:0]
instr_valid  input  1  instr holds a valid instruction
instr_ready  output  1  controller can accept an instruction this cycle
A_addr  output  2  register file read port A address
B_addr  output  2  register file read port B address
A_data  input  4  register file read port A data (combinational from A_addr)
B_data  input  4  register file read port B data (combinational from B_addr)
nWE  output  1  register file write enable, active low
D_addr  output  2  register file write address
D_data  output  4  register file write data
done  output  1  one-cycle pulse in the write-back cycle of each instruction
busy  output  1  high whenever the state is not IDLE
flag_z  output  1  zero flag: last ALU result == 0
flag_c  output  1  carry flag: ADD carry-out / SUB borrow

Behaviour:
- Opcodes: 000 NOP, 001 LDI rd<=imm, 010 MOV rd<=R[ra], 011 ADD rd<=R[ra]+R[rb], 100 SUB rd<=R[ra]-R[rb], 101 AND, 110 OR, 111 XOR.
- FSM states: IDLE, READ, EXEC, WB. IDLE->READ on instr_valid & instr_ready. READ->EXEC, EXEC->WB, and WB->IDLE are unconditional. Every opcode visits all four states, so throughput is 1 instruction per 4 cycles.
- instr_ready = 1 only in IDLE. instr is latched at the accepting edge. instr_valid is ignored in all other states.
- Accepting edge: A_addr<=ra, B_addr<=rb (registered), held until the next accept.
- READ: A_data/B_data captured into operand registers at the end of the cycle.
- EXEC: result computed from the captured operands into the result register; D_addr<=rd.
- WB: nWE=0 for exactly one cycle (except NOP, where nWE stays 1), D_addr=rd, D_data=result, done=1. The register file writes at the rising edge ending WB.
- Arithmetic:
  - ADD: 5-bit sum; result = sum[3:0], flag_c = sum[4].
  - SUB: result = (A-B) mod 16, flag_c = (A<B).
  - AND/OR/XOR: flag_c <= 0.
  - flag_z = (result==0) for ADD/SUB/AND/OR/XOR.
  - Flags update at the WB edge for those five ops only; NOP, LDI and MOV leave both flags unchanged.
- Hazards: the next instruction's READ occurs at least 2 cycles after the previous write, so back-to-back dependent instructions always read the updated value. No forwarding is needed.
- Reset (async, nRST=0), any state: state=IDLE, nWE=1, A_addr=B_addr=D_addr=0, D_data=0, done=0, busy=0, flag_z=0, flag_c=0, instr_ready=1 after release.
  - A reset asserted during WB suppresses the write immediately (nWE forced high).
  - Register file contents are not cleared by nRST.
- nWE is never low outside WB, and never low for two consecutive cycles.
- instr_valid held high continuously: a new instruction is accepted every 4th cycle.

Test Plan:
- Reset then LDI R1,0x5; LDI R2,0x3 -> R1=5, R2=3; each done pulse is 3 cycles after accept; nWE low exactly 1 cycle per instruction.
- ADD R3,R1,R2 after the loads -> R3=8, flag_c=0, flag_z=0. Then LDI R0,0xF; ADD R3,R0,R0 -> R3=0xE, flag_c=1.
- SUB R0,R2,R1 (3-5) -> R0=0xE, flag_c=1. Then XOR R1,R1,R1 -> R1=0, flag_z=1, flag_c=0.
- NOP, then MOV R2,R3 -> NOP: done pulses, nWE stays 1, flags unchanged. MOV: R2=R3 value, flags unchanged.
- Dependency chain LDI R0,1; ADD R0,R0,R0 x3 with instr_valid held high -> R0=8; accepts spaced exactly 4 cycles apart; instr_ready low during busy.
- Assert nRST during the WB of LDI R3,0x9 -> nWE returns high immediately, R3 unchanged, state IDLE, flags 0, busy 0.
